jstk_spi_responder: RTL and testbench
=====================================

JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 SHALL provide: clk50M  input  1  system clock, 50 MHz.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: cs  input  1  SPI chip select from master, active-low, asynchronous to clk50M.
REQ-004 SHALL provide: sck  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous.
REQ-005 SHALL provide: mosi  input  1  master-out data, MSB first.
REQ-006 SHALL provide: miso  output  1  slave-out data, MSB first.
REQ-007 SHALL provide: x_pos  input  10  joystick X value to report, unsigned.
REQ-008 SHALL provide: y_pos  input  10  joystick Y value to report, unsigned.
REQ-009 SHALL provide: buttons  input  3  button states to report.
REQ-010 SHALL provide: led  output  2  LED bits from last valid command byte.
REQ-011 SHALL provide: frame_done  output  1  one-cycle pulse on complete 5-byte frame.
REQ-012 SHALL provide: busy  output  1  high while a frame is in progress (synchronized cs low).

Function
REQ-013 cs, sck, mosi SHALL each pass through a two-flop synchronizer before use; edges detected on synchronized signals (pin-to-detect latency 3 clk50M cycles).
REQ-014 Supported SCK: high and low phases each >= 8 clk50M cycles (sck <= 3 MHz); faster SCK is unsupported.
REQ-015 FSM states: IDLE, SHIFT, DONE.
REQ-016 IDLE -> SHIFT on synchronized cs falling edge; same cycle, snapshot x_pos, y_pos, buttons into 40-bit tx frame; byte/bit counters cleared.
REQ-017 Tx frame order: byte0 = x[7:0], byte1 = {6'b0, x[9:8]}, byte2 = y[7:0], byte3 = {6'b0, y[9:8]}, byte4 = {5'b0, buttons}.
REQ-018 miso SHALL present tx bit 39 (byte0 MSB) within 1 cycle of cs-fall detection; advances one bit per synchronized sck falling edge.
REQ-019 mosi SHALL be sampled into an 8-bit rx shift register on each synchronized sck rising edge; bit counter 0..7, byte counter 0..4.
REQ-020 Only byte0 received (command byte) SHALL be kept; bytes 1..4 ignored.
REQ-021 After 40 rising edges, SHIFT -> DONE; further sck edges ignored, miso held 0.
REQ-022 DONE -> IDLE on cs rising: if command bit7 = 1, led <= command[1:0]; frame_done pulses 1 cycle; else led unchanged, frame_done still pulses.
REQ-023 cs rising while in SHIFT (abort, <40 bits): return to IDLE, led unchanged, no frame_done.
REQ-024 In IDLE, miso SHALL be 0 and sck/mosi activity ignored.
REQ-025 Snapshot SHALL NOT change during a frame regardless of x_pos/y_pos/buttons changes.
REQ-026 busy = 1 in SHIFT and DONE, 0 in IDLE.

Reset
REQ-027 Reset SHALL asynchronously force: state IDLE, miso 0, led 2'b00, frame_done 0, busy 0, counters 0, tx/rx registers 0, synchronizers to idle levels (cs 1, sck 0, mosi 0).
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, no activity until a new cs falling edge is detected.

Structure
REQ-029 Shared package pong_pkg SHALL hold: JSTK_FRAME_BYTES = 5, JSTK_CMD_VALID_BIT = 7, FSM state encoding.
REQ-030 One sub-module SHALL be used: spi_sync (two-flop synchronizer, reset value parameter), instantiated three times.

Verification
REQ-031 x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101, cmd 8'h83, 1 MHz sck -> miso bytes A5, 02, 3C, 01, 05; led=2'b11; one frame_done pulse.
REQ-032 cmd 8'h03 (bit7=0), full frame -> led unchanged from prior value, frame_done pulses once.
REQ-033 cs raised after 20 sck cycles -> no frame_done, led unchanged, busy 0 within 4 cycles, next frame reports fresh snapshot correctly.
REQ-034 x_pos changed 10'h000 -> 10'h3FF mid-frame -> frame still reports 10'h000 (bytes 00, 00).
REQ-035 reset pulsed during byte2 -> miso 0, led 00, busy 0 immediately; subsequent full frame with cmd 8'h81 -> led=2'b01.
REQ-036 48 sck cycles in one frame, cmd 8'h82 -> bits 41..48 on miso are 0; led=2'b10; exactly one frame_done.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared joystick-responder constants, FSM encoding and frame packer.
package pong_pkg;

    localparam int JSTK_FRAME_BYTES   = 5;
    localparam int JSTK_CMD_VALID_BIT = 7;
    localparam int JSTK_FRAME_BITS    = JSTK_FRAME_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } jstk_state_e;

    // Byte0 is transmitted first, so it occupies the MSBs of the frame.
    function automatic logic [JSTK_FRAME_BITS-1:0] jstk_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] b
    );
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// jstk_spi_responder_if: SPI pin bundle between a master and the joystick responder.
interface jstk_spi_responder_if;

    logic cs;
    logic sck;
    logic mosi;
    logic miso;

    modport master (output cs, output sck, output mosi, input miso);
    modport slave  (input cs, input sck, input mosi, output miso);

endinterface

// File: rtl/spi_sync.sv
// spi_sync: two-flop synchronizer with a configurable reset level.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ff_q <= {2{RST_VAL}};
        else       ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave reporting a 5-byte joystick frame and
// latching LED bits from a valid command byte.
module jstk_spi_responder
    import pong_pkg::*;
(
    input  logic                       clk50M,
    input  logic                       reset,
    jstk_spi_responder_if.slave        spi,
    input  logic [9:0]                 x_pos,
    input  logic [9:0]                 y_pos,
    input  logic [2:0]                 buttons,
    output logic [1:0]                 led,
    output logic                       frame_done,
    output logic                       busy
);

    logic cs_s, sck_s, mosi_s;
    logic cs_prev_q, sck_prev_q;

    spi_sync #(.RST_VAL(1'b1)) u_cs_sync   (.clk_i(clk50M), .rst_i(reset), .d_i(spi.cs),   .q_o(cs_s));
    spi_sync #(.RST_VAL(1'b0)) u_sck_sync  (.clk_i(clk50M), .rst_i(reset), .d_i(spi.sck),  .q_o(sck_s));
    spi_sync #(.RST_VAL(1'b0)) u_mosi_sync (.clk_i(clk50M), .rst_i(reset), .d_i(spi.mosi), .q_o(mosi_s));

    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_fall  =  cs_prev_q  & ~cs_s;
    assign cs_rise  = ~cs_prev_q  &  cs_s;
    assign sck_rise = ~sck_prev_q &  sck_s;
    assign sck_fall =  sck_prev_q & ~sck_s;

    jstk_state_e                state_q, state_d;
    logic [JSTK_FRAME_BITS-1:0] tx_q, tx_d;
    logic [7:0]                 rx_q, rx_d;
    logic [2:0]                 bit_q, bit_d;
    logic [2:0]                 byte_q, byte_d;
    logic [1:0]                 led_q, led_d;
    logic                       done_q, done_d;
    logic                       miso_q, miso_d;

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            led_q      <= '0;
            done_q     <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            led_q      <= led_d;
            done_q     <= done_d;
            miso_q     <= miso_d;
        end
    end

    // rx only shifts during byte0, so after that it simply holds the command.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        led_d   = led_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    tx_d    = jstk_frame(x_pos, y_pos, buttons);
                    rx_d    = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    rx_d  = (byte_q == 3'd0) ? {rx_q[6:0], mosi_s} : rx_q;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (byte_q == 3'(JSTK_FRAME_BYTES - 1)) state_d = ST_DONE;
                        else                                    byte_d  = byte_q + 3'd1;
                    end
                end else if (sck_fall) begin
                    tx_d = {tx_q[JSTK_FRAME_BITS-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    led_d   = rx_q[JSTK_CMD_VALID_BIT] ? rx_q[1:0] : led_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        miso_d = (state_d == ST_SHIFT) && tx_d[JSTK_FRAME_BITS-1];
    end

    assign spi.miso   = miso_q;
    assign led        = led_q;
    assign frame_done = done_q;
    assign busy       = state_q != ST_IDLE;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: directed table-driven bench for the joystick SPI responder.
module tb_jstk_spi_responder;

    logic       clk50M = 1'b0;
    logic       reset  = 1'b1;
    logic [9:0] x_pos, y_pos;
    logic [2:0] buttons;
    logic [1:0] led;
    logic       frame_done, busy;

    jstk_spi_responder_if spi_if ();

    jstk_spi_responder dut (
        .clk50M    (clk50M),
        .reset     (reset),
        .spi       (spi_if),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .buttons   (buttons),
        .led       (led),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #10ns clk50M = ~clk50M;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always @(posedge clk50M) if (frame_done) done_cnt++;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  b;
        logic [7:0]  cmd;
        logic [39:0] bytes;
        logic [1:0]  led;
    } vec_t;

    vec_t        vecs [4];
    logic [47:0] got;
    int          d0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 1 MHz mode-0 master: data set while sck low, miso sampled just before the rising edge.
    task automatic shift_bits(input logic [7:0] cmd, input int n, output logic [47:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            spi_if.mosi = (i < 8) ? cmd[7-i] : ~cmd[7-(i%8)];
            #500ns;
            bits[47-i] = spi_if.miso;
            spi_if.sck = 1'b1;
            #500ns;
            spi_if.sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n, output logic [47:0] bits);
        spi_if.cs = 1'b0;
        shift_bits(cmd, n, bits);
        #500ns;
        spi_if.cs = 1'b1;
        #200ns;
    endtask

    initial begin
        vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40'hA5023C0105, 2'b11};
        vecs[1] = '{10'h0FF, 10'h300, 3'b010, 8'h03, 40'hFF00000302, 2'b11};
        vecs[2] = '{10'h3FF, 10'h3FF, 3'b111, 8'h80, 40'hFF03FF0307, 2'b00};
        vecs[3] = '{10'h155, 10'h0AA, 3'b000, 8'h82, 40'h5501AA0000, 2'b10};

        spi_if.cs = 1'b1; spi_if.sck = 1'b0; spi_if.mosi = 1'b0;
        x_pos = '0; y_pos = '0; buttons = '0;
        #100ns;
        check("reset miso", 64'(spi_if.miso), 64'd0);
        check("reset led", 64'(led), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        reset = 1'b0;
        #100ns;

        spi_if.mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spi_if.sck = 1'b1; #100ns;
            spi_if.sck = 1'b0; #100ns;
        end
        check("idle busy", 64'(busy), 64'd0);
        check("idle miso", 64'(spi_if.miso), 64'd0);
        check("idle frames", 64'(done_cnt), 64'd0);

        for (int v = 0; v < 4; v++) begin
            x_pos = vecs[v].x; y_pos = vecs[v].y; buttons = vecs[v].b;
            d0 = done_cnt;
            run_frame(vecs[v].cmd, 40, got);
            check($sformatf("v%0d miso", v), 64'(got[47:8]), 64'(vecs[v].bytes));
            check($sformatf("v%0d led", v), 64'(led), 64'(vecs[v].led));
            check($sformatf("v%0d frame_done", v), 64'(done_cnt - d0), 64'd1);
            check($sformatf("v%0d busy", v), 64'(busy), 64'd0);
            check($sformatf("v%0d idle miso", v), 64'(spi_if.miso), 64'd0);
        end

        // Abort after 20 bits, then a fresh frame.
        x_pos = 10'h1AB; y_pos = 10'h2CD; buttons = 3'b110;
        d0 = done_cnt;
        spi_if.cs = 1'b0;
        shift_bits(8'hFF, 20, got);
        check("abort busy mid", 64'(busy), 64'd1);
        check("abort partial miso", 64'(got[47:28]), 64'h0AB01C);
        #100ns;
        spi_if.cs = 1'b1;
        #80ns;
        check("abort busy", 64'(busy), 64'd0);
        #200ns;
        check("abort frame_done", 64'(done_cnt - d0), 64'd0);
        check("abort led", 64'(led), 64'(2'b10));
        x_pos = 10'h0F0; y_pos = 10'h10F; buttons = 3'b001;
        d0 = done_cnt;
        run_frame(8'h00, 40, got);
        check("post-abort miso", 64'(got[47:8]), 64'hF0000F0101);
        check("post-abort led", 64'(led), 64'(2'b10));
        check("post-abort frame_done", 64'(done_cnt - d0), 64'd1);

        // Inputs change mid-frame; the snapshot must not.
        x_pos = 10'h000; y_pos = 10'h2C3; buttons = 3'b011;
        fork
            run_frame(8'h00, 40, got);
            begin
                #3000ns;
                x_pos = 10'h3FF; y_pos = 10'h000; buttons = 3'b000;
            end
        join
        check("snapshot miso", 64'(got[47:8]), 64'h0000C30203);
        check("snapshot led", 64'(led), 64'(2'b10));

        // Reset during byte2.
        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
        spi_if.cs = 1'b0;
        shift_bits(8'h83, 20, got);
        check("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #2ns;
        check("midreset miso", 64'(spi_if.miso), 64'd0);
        check("midreset led", 64'(led), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        #18ns;
        spi_if.cs = 1'b1;
        #100ns;
        reset = 1'b0;
        #200ns;
        check("post-reset busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        run_frame(8'h81, 40, got);
        check("post-reset miso", 64'(got[47:8]), 64'hA5023C0105);
        check("post-reset led", 64'(led), 64'(2'b01));
        check("post-reset frame_done", 64'(done_cnt - d0), 64'd1);

        // 48 sck cycles in one frame.
        x_pos = 10'h1E7; y_pos = 10'h299; buttons = 3'b100;
        d0 = done_cnt;
        run_frame(8'h82, 48, got);
        check("long miso", 64'(got[47:8]), 64'hE701990204);
        check("long tail bits", 64'(got[7:0]), 64'd0);
        check("long led", 64'(led), 64'(2'b10));
        check("long frame_done", 64'(done_cnt - d0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
